dac_tx_sched: RTL and testbench
===============================

Name: dac_tx_sched

Overview:
Write-side controller for the DAC transmit sample FIFO. It arbitrates two 32-bit sample requesters (0 = host stream, 1 = internal pattern source) onto the single FIFO write port, one burst at a time. It sequences streaming through prefill, run and drain, and it gates DAC transmission. It throttles on the FIFO write count and flags underruns. It sits in the `clk` domain, directly upstream of the FIFO `data_we`/`data_in`/`fifo_data_cnt` interface.

Parameters:
- PREFILL_LVL, 1024: FIFO word count required before transmission starts.
- HIGH_WM, 30000: writes are blocked while `fifo_data_cnt >= HIGH_WM` (margin for count lag).
- BURST_LEN, 64: maximum beats per grant before the arbiter rotates.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = stream, 0 = stop and drain
- req0_valid  in  1  host sample valid
- req0_data  in  32  host sample pair
- req0_ready  out  1  host sample accepted this cycle
- req1_valid  in  1  pattern sample valid
- req1_data  in  32  pattern sample pair
- req1_ready  out  1  pattern sample accepted this cycle
- data_we  out  1  FIFO write enable
- data_in  out  32  FIFO write data
- fifo_data_cnt  in  16  FIFO write count (bit 15 always 0)
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty (synchronous to clk)
- tx_run  out  1  DAC transmit gate
- state_o  out  2  current state: 0 IDLE, 1 PREFILL, 2 RUN, 3 DRAIN
- underrun  out  1  sticky underrun flag
- underrun_cnt  out  16  saturating underrun event count
- underrun_clr  in  1  pulse; clears `underrun` and `underrun_cnt`

Behaviour:
- Reset (async, `reset_n=0`): state IDLE; grant=0; burst counter 0; all outputs 0.
- space_ok = `!fifo_full && fifo_data_cnt < HIGH_WM`.
- `reqN_ready` = (state is PREFILL or RUN) && space_ok && grant==N. Combinational; at most one ready high per cycle.
- A beat transfers when `reqN_valid && reqN_ready`.
- Write latency: on a transfer at cycle t, `data_we=1` and `data_in=reqN_data` at t+1 (registered). Otherwise `data_we=0`, and `data_in` holds its last value.
- Arbitration, evaluated only on cycles with no transfer or at burst end:
  - Rotate to the other requester when BURST_LEN beats have transferred on the current grant, or when the granted valid is 0 while the other valid is 1.
  - If neither valid is high, hold the grant.
  - The burst counter resets to 0 on every grant change.
  - The grant never changes in the same cycle as a transfer, except on the BURST_LEN-th beat, where it changes in the following cycle.
- FSM:
  - IDLE: `tx_run=0`. `enable=1` → PREFILL.
  - PREFILL: `tx_run=0`.
    - `enable=0` → DRAIN.
    - `fifo_data_cnt >= PREFILL_LVL` → RUN.
  - RUN: `tx_run=1`.
    - `enable=0` → DRAIN.
    - `fifo_empty=1` → underrun event (see below); stay in RUN.
  - DRAIN: `readys=0`, `tx_run=1` until `fifo_empty=1`, then IDLE, with `tx_run=0` in the same cycle as the transition.
  - `enable` re-asserted during DRAIN is ignored until IDLE is reached.
- Underrun event: a rising edge of `fifo_empty` while in RUN. It sets `underrun` and increments `underrun_cnt`, saturating at 0xFFFF.
  - `underrun_clr` wins over a simultaneous event: count reads 0 the next cycle.
- Width rule: compare only `fifo_data_cnt[14:0]`; ignore bit 15.
- Reset mid-burst: any in-flight registered write is dropped (`data_we=0` immediately). Upstream must treat the FIFO as discarded.

Test Plan:
- Reset then `enable=1`, req0 streams continuously → state PREFILL; `tx_run` stays 0 until the bench raises `fifo_data_cnt` to 1024; RUN and `tx_run=1` on the next clk.
- Both valids held high in RUN with the count low → grants alternate in exactly 64-beat bursts, starting with req0. Each `data_we` lags its handshake by 1 cycle with matching data.
- `fifo_data_cnt` raised to 30000 mid-burst → both readys drop the same cycle; `data_we` falls 1 cycle later; writes resume when the count returns to 29999.
- req0 valid drops after 10 beats while req1 is valid → grant moves to req1 within 1 cycle; the req1 burst counter starts at 0.
- In RUN, `fifo_empty` pulsed 3 times → `underrun=1`, `underrun_cnt=3`. `underrun_clr` coincident with a 4th pulse → count 0.
- `enable=0` in RUN → DRAIN; readys 0; `tx_run` stays 1 until `fifo_empty=1`, then IDLE with `tx_run=0`. Asserting `reset_n=0` asynchronously mid-transfer zeroes `data_we` and `tx_run` without waiting for a clock.

Source files
------------

// File: rtl/dac_tx_sched_if.sv
// Sample-path bundle between the two requesters, the scheduler and the TX FIFO write port.
// The slave side is the scheduler; the master side is the surrounding requesters/FIFO.
interface dac_tx_sched_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        data_we;
  logic [31:0] data_in;
  logic [15:0] fifo_data_cnt;
  logic        fifo_full;
  logic        fifo_empty;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_data_cnt, fifo_full, fifo_empty,
    input  req0_ready, req1_ready, data_we, data_in
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_data_cnt, fifo_full, fifo_empty,
    output req0_ready, req1_ready, data_we, data_in
  );
endinterface

// File: rtl/dac_tx_sched.sv
// DAC transmit FIFO write scheduler: two-requester burst arbiter, prefill/run/drain
// sequencing of the DAC transmit gate, high-watermark throttling and underrun tracking.
module dac_tx_sched #(
  parameter int PREFILL_LVL = 1024,
  parameter int HIGH_WM     = 30000,
  parameter int BURST_LEN   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  dac_tx_sched_if.slave      bus,
  output logic               tx_run,
  output logic [1:0]         state_o,
  output logic               underrun,
  output logic [15:0]        underrun_cnt,
  input  logic               underrun_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [15:0] HIGH_WM_C  = 16'(HIGH_WM);
  localparam logic [15:0] PREFILL_C  = 16'(PREFILL_LVL);

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_nxt;
  logic             active;
  logic             space_ok;
  logic             prefill_ok;
  logic             xfer;
  logic             gnt_valid, oth_valid;
  logic [31:0]      xfer_data;
  logic             empty_q;
  logic             ur_evt;
  logic [15:0]      cnt_eff;

  // Bit 15 of the FIFO count is never meaningful; mask it before any threshold compare.
  always_comb begin
    cnt_eff    = bus.fifo_data_cnt & 16'h7FFF;
    space_ok   = !bus.fifo_full && (cnt_eff < HIGH_WM_C);
    prefill_ok = (cnt_eff >= PREFILL_C);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic plus the transmit gate and the write-window qualifier.
  always_comb begin
    state_nxt = state;
    tx_run    = 1'b0;
    active    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = PREFILL;
      end
      PREFILL: begin
        active = 1'b1;
        if (!enable)         state_nxt = DRAIN;
        else if (prefill_ok) state_nxt = RUN;
      end
      RUN: begin
        active = 1'b1;
        tx_run = 1'b1;
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.fifo_empty) state_nxt = IDLE;
        else                tx_run    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready/handshake decode; only the granted requester can be ready.
  always_comb begin
    bus.req0_ready = active && space_ok && !grant;
    bus.req1_ready = active && space_ok &&  grant;
    xfer      = (bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid);
    xfer_data = grant ? bus.req1_data : bus.req0_data;
    gnt_valid = grant ? bus.req1_valid : bus.req0_valid;
    oth_valid = grant ? bus.req0_valid : bus.req1_valid;
    state_o   = state;
  end

  // Grant rotation: a full burst flips the grant after its last beat; otherwise the
  // grant only moves on an idle cycle where the other side is waiting.
  always_comb begin
    grant_nxt = grant;
    beat_nxt  = beat_cnt;
    if (xfer) begin
      if (beat_cnt == BEAT_LAST) begin
        grant_nxt = ~grant;
        beat_nxt  = '0;
      end else begin
        beat_nxt  = beat_cnt + 1'b1;
      end
    end else if (!gnt_valid && oth_valid) begin
      grant_nxt = ~grant;
      beat_nxt  = '0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      grant    <= grant_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // One-cycle registered FIFO write; data holds between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.data_we <= 1'b0;
      bus.data_in <= '0;
    end else begin
      bus.data_we <= xfer;
      if (xfer) bus.data_in <= xfer_data;
    end
  end

  assign ur_evt = (state == RUN) && bus.fifo_empty && !empty_q;

  // Underrun tracking: sticky flag and saturating count, clear has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      empty_q      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      empty_q <= bus.fifo_empty;
      if (underrun_clr) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end else if (ur_evt) begin
        underrun <= 1'b1;
        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dac_tx_sched.sv
// Self-checking bench for dac_tx_sched: a cycle model predicts readys, state and the
// transmit gate; accepted beats go into a scoreboard queue and are popped when the
// registered FIFO write should appear.
module tb_dac_tx_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        underrun_clr;
  logic        tx_run;
  logic [1:0]  state_o;
  logic        underrun;
  logic [15:0] underrun_cnt;

  dac_tx_sched_if bus();

  dac_tx_sched #(
    .PREFILL_LVL (1024),
    .HIGH_WM     (30000),
    .BURST_LEN   (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .bus          (bus),
    .tx_run       (tx_run),
    .state_o      (state_o),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model state (valid for the cycle that starts at the next posedge).
  int          m_state;
  bit          m_grant;
  int          m_beat;
  bit          m_we;
  logic [31:0] m_din;
  bit          m_eq;
  bit          m_ur;
  int          m_urc;
  logic [31:0] sb[$];

  bit          space, act, r0, r1, x0, x1, gv, ov, evt, exp_tx;

  task automatic model_reset();
    m_state = 0; m_grant = 0; m_beat = 0; m_we = 0; m_din = '0;
    m_eq = 0; m_ur = 0; m_urc = 0;
    sb.delete();
  endtask

  // Check outputs mid-cycle, then advance the model past the coming posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      space  = !bus.fifo_full && (bus.fifo_data_cnt[14:0] < 15'd30000);
      act    = (m_state == 1) || (m_state == 2);
      r0     = act && space && !m_grant;
      r1     = act && space &&  m_grant;
      exp_tx = (m_state == 2) || (m_state == 3 && !bus.fifo_empty);

      check("req0_ready",   32'(bus.req0_ready), 32'(r0));
      check("req1_ready",   32'(bus.req1_ready), 32'(r1));
      check("state_o",      32'(state_o),        32'(m_state));
      check("tx_run",       32'(tx_run),         32'(exp_tx));
      check("data_we",      32'(bus.data_we),    32'(m_we));
      if (m_we && sb.size() > 0) m_din = sb.pop_front();
      check("data_in",      bus.data_in,         m_din);
      check("underrun",     32'(underrun),       32'(m_ur));
      check("underrun_cnt", 32'(underrun_cnt),   32'(m_urc));

      x0 = r0 && bus.req0_valid;
      x1 = r1 && bus.req1_valid;
      if (x0) sb.push_back(bus.req0_data);
      if (x1) sb.push_back(bus.req1_data);
      m_we = x0 || x1;

      gv = m_grant ? bus.req1_valid : bus.req0_valid;
      ov = m_grant ? bus.req0_valid : bus.req1_valid;
      if (m_we) begin
        if (m_beat == 63) begin m_grant = !m_grant; m_beat = 0; end
        else m_beat++;
      end else if (!gv && ov) begin
        m_grant = !m_grant; m_beat = 0;
      end

      evt  = (m_state == 2) && bus.fifo_empty && !m_eq;
      m_eq = bus.fifo_empty;
      if (underrun_clr) begin
        m_ur = 0; m_urc = 0;
      end else if (evt) begin
        m_ur = 1;
        if (m_urc < 16'hFFFF) m_urc++;
      end

      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = 3;
           else if (bus.fifo_data_cnt[14:0] >= 15'd1024) m_state = 2;
        2: if (!enable) m_state = 3;
        default: if (bus.fifo_empty) m_state = 0;
      endcase
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.req0_data = $urandom;
      bus.req1_data = $urandom;
    end
  endtask

  bit found;

  initial begin
    model_reset();
    reset_n           = 1'b0;
    enable            = 1'b0;
    underrun_clr      = 1'b0;
    bus.req0_valid    = 1'b0;
    bus.req1_valid    = 1'b0;
    bus.req0_data     = '0;
    bus.req1_data     = '0;
    bus.fifo_data_cnt = '0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty    = 1'b0;

    #12;
    check("rst_data_we",  32'(bus.data_we),    0);
    check("rst_data_in",  bus.data_in,         0);
    check("rst_tx_run",   32'(tx_run),         0);
    check("rst_state",    32'(state_o),        0);
    check("rst_ready0",   32'(bus.req0_ready), 0);
    check("rst_underrun", 32'(underrun_cnt),   0);

    step(1);
    reset_n = 1'b1;
    step(2);

    // Prefill with host stream, then cross the prefill level.
    enable = 1'b1;
    bus.req0_valid = 1'b1;
    step(20);
    check("prefill_state", 32'(state_o), 1);
    check("prefill_txrun", 32'(tx_run),  0);
    bus.fifo_data_cnt = 16'd1024;
    step(1);
    check("run_state", 32'(state_o), 2);
    check("run_txrun", 32'(tx_run),  1);

    // Both requesters streaming: 64-beat alternating bursts.
    bus.fifo_data_cnt = 16'd100;
    bus.req1_valid = 1'b1;
    step(200);

    // High watermark, bit-15 masking and FIFO full throttling.
    bus.fifo_data_cnt = 16'd30000;
    step(3);
    check("hwm_ready0", 32'(bus.req0_ready), 0);
    check("hwm_ready1", 32'(bus.req1_ready), 0);
    bus.fifo_data_cnt = 16'd29999;
    step(10);
    bus.fifo_data_cnt = 16'h8000 | 16'd100;
    step(10);
    bus.fifo_full = 1'b1;
    step(3);
    bus.fifo_full = 1'b0;
    step(5);

    // Host drops out after 10 beats of its burst; grant moves to the pattern source.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (!m_grant && m_beat == 10) found = 1;
      else step(1);
    end
    check("find_beat10", 32'(found), 1);
    bus.req0_valid = 1'b0;
    step(1);
    check("gnt_moved", 32'(bus.req1_ready), 1);
    step(30);
    bus.req0_valid = 1'b1;
    step(100);

    // Underrun events and a clear that collides with a fourth event.
    for (int i = 0; i < 3; i++) begin
      bus.fifo_empty = 1'b1;
      step(1);
      bus.fifo_empty = 1'b0;
      step(1);
    end
    check("ur_flag", 32'(underrun),     1);
    check("ur_cnt3", 32'(underrun_cnt), 3);
    bus.fifo_empty = 1'b1;
    underrun_clr   = 1'b1;
    step(1);
    underrun_clr   = 1'b0;
    bus.fifo_empty = 1'b0;
    check("ur_clr_cnt",  32'(underrun_cnt), 0);
    check("ur_clr_flag", 32'(underrun),     0);
    step(3);

    // Stop: drain with tx gate held until empty; re-enable is ignored meanwhile.
    enable = 1'b0;
    step(1);
    check("drain_state", 32'(state_o), 3);
    check("drain_txrun", 32'(tx_run),  1);
    step(3);
    enable = 1'b1;
    step(3);
    check("drain_hold", 32'(state_o), 3);
    bus.fifo_empty = 1'b1;
    #2;
    check("drain_exit_txrun", 32'(tx_run), 0);
    step(1);
    check("idle_state", 32'(state_o), 0);
    step(1);
    check("reprefill_state", 32'(state_o), 1);
    bus.fifo_empty    = 1'b0;
    bus.fifo_data_cnt = 16'd2000;
    step(2);
    bus.fifo_data_cnt = 16'd100;
    step(5);

    // Asynchronous reset in the middle of a transfer.
    check("pre_rst_we", 32'(bus.data_we), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_data_we", 32'(bus.data_we), 0);
    check("arst_tx_run",  32'(tx_run),      0);
    check("arst_state",   32'(state_o),     0);
    step(2);
    reset_n = 1'b1;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
